// File: rtl/ram_pkg.sv
// Shared types for the dual-port scratch RAM.
package ram_pkg;

  // Cross-port read/write ordering when both ports hit the same word in one cycle.
  typedef enum logic {
    WRITE_FIRST,
    READ_FIRST
  } wr_mode_e;

  // INIT clears the array one word per cycle; RUN serves requests.
  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Per-port read return pipeline: RD_LAT stages of valid/data delay.
// Data registers load only alongside a valid, so the output holds its last value
// while out_valid is low.
module ram_rd_pipe #(
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [RD_LAT-1:0] vld_q;
  logic [DW-1:0]     dat_q [RD_LAT];

  // Shift valid every cycle; move data only with its valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        dat_q[0] <= in_data;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/ram_dp_sc.sv
// Dual-port single-clock RAM with byte enables, power-up clear sequence,
// cross-port collision handling and out-of-range detection.
module ram_dp_sc
  import ram_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 2 ** AW,
  parameter int unsigned RD_LAT  = 1,
  parameter wr_mode_e    WR_MODE = WRITE_FIRST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW/8-1:0] a_be,
  input  logic [DW-1:0]   a_wdata,
  output logic            a_rvalid,
  output logic [DW-1:0]   a_rdata,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW/8-1:0] b_be,
  input  logic [DW-1:0]   b_wdata,
  output logic            b_rvalid,
  output logic [DW-1:0]   b_rdata,
  output logic            init_busy,
  output logic            collision,
  output logic            oor_err
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] mem [DEPTH];

  logic          run;
  logic          a_hit, b_hit, a_oor, b_oor, a_wr, b_wr, a_rd, b_rd, same_addr;
  logic [IW-1:0] a_idx, b_idx, cnt_idx;
  logic [BW-1:0] a_wbe, b_wbe;
  logic [DW-1:0] a_old, b_old, a_rdata_d, b_rdata_d;
  logic          collision_d, oor_d, collision_q, oor_q;

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequence: one word per cycle, leave INIT after the last word, never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (cnt_q == LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  assign init_busy = (state_q == INIT);
  assign run       = (state_q == RUN);

  assign a_idx   = a_addr[IW-1:0];
  assign b_idx   = b_addr[IW-1:0];
  assign cnt_idx = cnt_q[IW-1:0];

  // Request decode; everything is masked while the clear sequence runs.
  always_comb begin
    a_hit     = run && a_req;
    b_hit     = run && b_req;
    a_oor     = ({1'b0, a_addr} >= DEPTH_W);
    b_oor     = ({1'b0, b_addr} >= DEPTH_W);
    a_wr      = a_hit && a_we && !a_oor;
    b_wr      = b_hit && b_we && !b_oor;
    a_rd      = a_hit && !a_we;
    b_rd      = b_hit && !b_we;
    same_addr = (a_addr == b_addr);
    a_wbe     = a_wr ? a_be : '0;
    // Port A owns overlapping bytes on a same-word double write.
    b_wbe     = b_wr ? ((a_wr && same_addr) ? (b_be & ~a_be) : b_be) : '0;
    collision_d = a_hit && b_hit && same_addr && (a_we || b_we);
    oor_d       = (a_hit && a_oor) || (b_hit && b_oor);
  end

  // Read data at the request edge; out-of-range reads return zero, and in
  // WRITE_FIRST mode the other port's same-word write bytes are forwarded.
  always_comb begin
    a_old     = a_oor ? '0 : mem[a_idx];
    b_old     = b_oor ? '0 : mem[b_idx];
    a_rdata_d = a_old;
    b_rdata_d = b_old;
    if (WR_MODE == WRITE_FIRST) begin
      for (int i = 0; i < BW; i++) begin
        if (b_wr && same_addr && b_be[i]) begin
          a_rdata_d[8*i +: 8] = b_wdata[8*i +: 8];
        end
        if (a_wr && same_addr && a_be[i]) begin
          b_rdata_d[8*i +: 8] = a_wdata[8*i +: 8];
        end
      end
    end
  end

  // Storage: clear one word during INIT, otherwise up to two byte-masked writes.
  // Write masks are disjoint on a shared word, so the two writes never overlap.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_idx] <= '0;
    end else begin
      for (int i = 0; i < BW; i++) begin
        if (a_wbe[i]) begin
          mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
        end
        if (b_wbe[i]) begin
          mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
        end
      end
    end
  end

  // Single-cycle status pulses, registered from the request edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      collision_q <= collision_d;
      oor_q       <= oor_d;
    end
  end

  assign collision = collision_q;
  assign oor_err   = oor_q;

  ram_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_pipe_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_rd),
    .in_data   (a_rdata_d),
    .out_valid (a_rvalid),
    .out_data  (a_rdata)
  );

  ram_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_pipe_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_rd),
    .in_data   (b_rdata_d),
    .out_valid (b_rvalid),
    .out_data  (b_rdata)
  );

endmodule

// File: tb/tb_ram_dp_sc.sv
// Scoreboard bench for ram_dp_sc: two instances (WRITE_FIRST/RD_LAT=1 and
// READ_FIRST/RD_LAT=2) share one stimulus stream; a word-array model predicts
// responses, and a negedge monitor checks them.
module tb_ram_dp_sc;
  import ram_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [3:0]    a_be, b_be;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          wf_a_rvalid, wf_b_rvalid, rf_a_rvalid, rf_b_rvalid;
  logic [DW-1:0] wf_a_rdata, wf_b_rdata, rf_a_rdata, rf_b_rdata;
  logic          wf_busy, rf_busy, wf_coll, rf_coll, wf_oor, rf_oor;

  ram_dp_sc #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(1), .WR_MODE(WRITE_FIRST)
  ) u_wf (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .a_rvalid(wf_a_rvalid), .a_rdata(wf_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_rvalid(wf_b_rvalid), .b_rdata(wf_b_rdata),
    .init_busy(wf_busy), .collision(wf_coll), .oor_err(wf_oor)
  );

  ram_dp_sc #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(2), .WR_MODE(READ_FIRST)
  ) u_rf (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .a_rvalid(rf_a_rvalid), .a_rdata(rf_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_rvalid(rf_b_rvalid), .b_rdata(rf_b_rdata),
    .init_busy(rf_busy), .collision(rf_coll), .oor_err(rf_oor)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  // Streams 0..3: wf.a, wf.b, rf.a, rf.b. Pulses 0..3: wf.coll, wf.oor, rf.coll, rf.oor.
  exp_t        rq [4][$];
  int          pq [4][$];
  logic [31:0] hold [4];
  logic        rv [4];
  logic [31:0] rd [4];
  logic        pv [4];

  assign rv[0] = wf_a_rvalid;
  assign rv[1] = wf_b_rvalid;
  assign rv[2] = rf_a_rvalid;
  assign rv[3] = rf_b_rvalid;
  assign rd[0] = wf_a_rdata;
  assign rd[1] = wf_b_rdata;
  assign rd[2] = rf_a_rdata;
  assign rd[3] = rf_b_rdata;
  assign pv[0] = wf_coll;
  assign pv[1] = wf_oor;
  assign pv[2] = rf_coll;
  assign pv[3] = rf_oor;

  int          cyc = 0;
  int          run_from = 1 << 30;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] mem_m [DEPTH];
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_addr = '0; a_be = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_be = '0; b_wdata = '0;
  endtask

  // Drive one cycle's requests and apply the reference rules to the model.
  task automatic drive(input logic ar, input logic aw, input int aa, input logic [3:0] ab,
                       input logic [31:0] ad, input logic br, input logic bw, input int ba,
                       input logic [3:0] bb, input logic [31:0] bd);
    logic [31:0] old [DEPTH];
    a_req = ar; a_we = aw; a_addr = AW'(aa); a_be = ab; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = AW'(ba); b_be = bb; b_wdata = bd;
    if (rst_n && cyc >= run_from) begin
      old = mem_m;
      if (ar && br && aa == ba && (aw || bw)) begin
        pq[0].push_back(cyc + 1);
        pq[2].push_back(cyc + 1);
      end
      if ((ar && aa >= DEPTH) || (br && ba >= DEPTH)) begin
        pq[1].push_back(cyc + 1);
        pq[3].push_back(cyc + 1);
      end
      // B first, then A, so A owns overlapping bytes.
      if (br && bw && ba < DEPTH)
        for (int i = 0; i < 4; i++) if (bb[i]) mem_m[ba][8*i +: 8] = bd[8*i +: 8];
      if (ar && aw && aa < DEPTH)
        for (int i = 0; i < 4; i++) if (ab[i]) mem_m[aa][8*i +: 8] = ad[8*i +: 8];
      if (ar && !aw) begin
        rq[0].push_back('{cyc + 1, (aa < DEPTH) ? mem_m[aa] : 32'h0});
        rq[2].push_back('{cyc + 2, (aa < DEPTH) ? old[aa] : 32'h0});
      end
      if (br && !bw) begin
        rq[1].push_back('{cyc + 1, (ba < DEPTH) ? mem_m[ba] : 32'h0});
        rq[3].push_back('{cyc + 2, (ba < DEPTH) ? old[ba] : 32'h0});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic op(input logic ar, input logic aw, input int aa, input logic [3:0] ab,
                    input logic [31:0] ad, input logic br, input logic bw, input int ba,
                    input logic [3:0] bb, input logic [31:0] bd);
    drive(ar, aw, aa, ab, ad, br, bw, ba, bb, bd);
    step();
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 19));
  endfunction

  task automatic rnd_op();
    op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), 4'($urandom),
       $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(),
       4'($urandom), $urandom);
  endtask

  task automatic read_all();
    for (int k = 0; k < DEPTH; k++) op(1, 0, k, 4'h0, 0, 1, 0, DEPTH - 1 - k, 4'h0, 0);
  endtask

  task automatic count_init(input string name);
    int n = 0;
    while (wf_busy && n < 100) begin
      n++;
      rnd_op();
    end
    chk(name, n, 16);
  endtask

  // Monitor: pop expected reads when rvalid shows, check hold, pulses and init_busy.
  always @(negedge clk) begin
    logic exp_p;
    logic exp_b;
    for (int i = 0; i < 4; i++) begin
      if (rv[i]) begin
        n_tests++;
        if (rq[i].size() == 0) begin
          n_fail++;
          $display("FAIL rvalid[%0d] cyc %0d: got unexpected rvalid data %h, expected none",
                   i, cyc, rd[i]);
        end else begin
          mon_e = rq[i].pop_front();
          if (mon_e.due != cyc || mon_e.data !== rd[i]) begin
            n_fail++;
            $display("FAIL rdata[%0d]: got %h at cyc %0d, expected %h at cyc %0d",
                     i, rd[i], cyc, mon_e.data, mon_e.due);
          end
          hold[i] = mon_e.data;
        end
      end else begin
        if (rq[i].size() != 0 && rq[i][0].due <= cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL rvalid[%0d]: got none at cyc %0d, expected data %h",
                   i, cyc, rq[i][0].data);
          void'(rq[i].pop_front());
        end
        n_tests++;
        if (rd[i] !== hold[i]) begin
          n_fail++;
          $display("FAIL rdata_hold[%0d] cyc %0d: got %h, expected %h", i, cyc, rd[i], hold[i]);
        end
      end
      while (pq[i].size() != 0 && pq[i][0] < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL pulse[%0d]: got none, expected pulse at cyc %0d", i, pq[i][0]);
        void'(pq[i].pop_front());
      end
      exp_p = (pq[i].size() != 0 && pq[i][0] == cyc);
      if (exp_p) void'(pq[i].pop_front());
      if (pv[i] || exp_p) begin
        n_tests++;
        if (pv[i] !== exp_p) begin
          n_fail++;
          $display("FAIL pulse[%0d] cyc %0d: got %b, expected %b", i, cyc, pv[i], exp_p);
        end
      end
    end
    exp_b = !rst_n || (cyc < run_from);
    n_tests++;
    if (wf_busy !== exp_b || rf_busy !== exp_b) begin
      n_fail++;
      $display("FAIL init_busy cyc %0d: got %b/%b, expected %b", cyc, wf_busy, rf_busy, exp_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    for (int i = 0; i < 4; i++) hold[i] = '0;
    for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("reset_rdata", rd[i], 0);
    chk("reset_busy", {wf_busy, rf_busy}, 2'b11);

    // Release reset; random traffic during INIT must be ignored.
    rst_n = 1;
    run_from = cyc + 16;
    count_init("init_len");
    read_all();

    op(1, 1, 3, 4'hF, 32'hDEADBEEF, 0, 0, 0, 4'h0, 0);
    op(0, 0, 0, 4'h0, 0, 1, 0, 3, 4'h0, 0);
    op(1, 1, 5, 4'h3, 32'h11111111, 1, 1, 5, 4'hF, 32'h22222222);
    op(1, 0, 5, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    op(1, 1, 7, 4'hF, 32'hAAAA5555, 1, 0, 7, 4'h0, 0);
    op(1, 0, 7, 4'h0, 0, 1, 0, 20, 4'h0, 0);
    op(0, 0, 0, 4'h0, 0, 1, 1, 20, 4'hF, 32'hCAFEF00D);
    op(1, 0, 4, 4'h0, 0, 1, 0, 4, 4'h0, 0);
    op(1, 0, 9, 4'h0, 0, 1, 0, 9, 4'h0, 0);

    repeat (400) rnd_op();

    // Reset in the middle of a two-read burst.
    op(1, 0, 3, 4'h0, 0, 1, 0, 9, 4'h0, 0);
    drive(1, 0, 4, 4'h0, 0, 1, 0, 10, 4'h0, 0);
    #1;
    rst_n = 0;
    run_from = 1 << 30;
    for (int i = 0; i < 4; i++) begin
      rq[i].delete();
      pq[i].delete();
      hold[i] = '0;
    end
    idle();
    #1;
    for (int i = 0; i < 4; i++) chk("midreset_rdata", rd[i], 0);
    chk("midreset_rvalid", {rv[0], rv[1], rv[2], rv[3]}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    run_from = cyc + 16;
    for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
    count_init("reinit_len");
    read_all();
    repeat (40) rnd_op();

    repeat (6) step();
    for (int i = 0; i < 4; i++) begin
      chk("rq_drained", rq[i].size(), 0);
      chk("pq_drained", pq[i].size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_sc.md
RAM_DP_SC -- requirements
Module: ram_dp_sc

Interface
REQ-001 Parameters SHALL be as follows:
- AW, 8: address width.
- DW, 32: data width; SHALL be a multiple of 8.
- DEPTH, 2**AW: number of words; SHALL be at most 2**AW.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2.
- WR_MODE, WRITE_FIRST: same-port read-during-write behaviour; legal values WRITE_FIRST or READ_FIRST.
REQ-002 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be as follows:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- {a,b}_req  in  1  access request, per port.
- {a,b}_we  in  1  1 = write, 0 = read.
- {a,b}_addr  in  AW  word address.
- {a,b}_be  in  DW/8  byte enables, used on writes only.
- {a,b}_wdata  in  DW  write data.
- {a,b}_rvalid  out  1  read data valid.
- {a,b}_rdata  out  DW  read data.
- init_busy  out  1  memory clear in progress.
- collision  out  1  one-cycle pulse on a same-address conflict.
- oor_err  out  1  one-cycle pulse on an address >= DEPTH.

Function
REQ-004 The state machine SHALL have two states, INIT and RUN; reset SHALL enter INIT.
REQ-005 In INIT, an AW-bit counter SHALL write zero to one word per cycle, addresses 0 to DEPTH-1; after the DEPTH-1 write the FSM SHALL go to RUN; INIT SHALL last exactly DEPTH cycles.
REQ-006 init_busy SHALL be 1 in INIT and 0 in RUN.
REQ-007 Requests that arrive while init_busy=1 SHALL be ignored: no write, no rvalid, no error pulse.
REQ-008 In RUN, a write (req=1, we=1) SHALL update byte i of mem[addr] iff be[i]=1, at the clock edge where the request is sampled.
REQ-009 A read (req=1, we=0) SHALL assert rvalid exactly RD_LAT cycles after the request cycle, with rdata = mem[addr] as sampled at the request edge.
REQ-010 Reads SHALL be fully pipelined: one read per port per cycle, with back-to-back rvalid.
REQ-011 rdata SHALL hold its last value while rvalid=0.
REQ-012 Same-port read-during-write: each port issues at most one operation per cycle, so WR_MODE applies to cross-port same-address read/write in the same cycle.
- WRITE_FIRST: the reader SHALL receive the merged new data, with write bytes selected by be.
- READ_FIRST: the reader SHALL receive the old data.
REQ-013 If both ports write the same address in the same cycle, port A bytes SHALL win where their be overlap, port B's non-overlapping enabled bytes SHALL still be written, and collision SHALL pulse for 1 cycle, registered at the following edge.
REQ-014 A cross-port same-address read/write SHALL also pulse collision.
REQ-015 Two reads of the same address SHALL NOT pulse collision.
REQ-016 For addr >= DEPTH: writes SHALL be dropped, reads SHALL return zero with normal rvalid timing, and oor_err SHALL pulse 1 cycle, registered.
REQ-017 Wrap-around: the INIT counter SHALL stop at DEPTH-1 and SHALL NOT wrap into a second pass.

Reset
REQ-018 Asserting rst_n=0 SHALL immediately clear:
- FSM to INIT, counter to 0;
- all rvalid, collision and oor_err to 0;
- all rdata to 0;
- the read pipeline, discarding in-flight reads.
REQ-019 init_busy SHALL read 1 during reset.
REQ-020 Reset mid-INIT or mid-RUN SHALL restart the full clear sequence from address 0 after deassertion.
REQ-021 Memory array contents SHALL NOT be reset directly; only INIT clears them.

Structure
REQ-022 A package ram_pkg SHALL hold the wr_mode_e enum (WRITE_FIRST, READ_FIRST) and the state typedef (INIT, RUN).
REQ-023 One sub-module, ram_rd_pipe, SHALL implement the per-port RD_LAT-deep valid/data delay; it SHALL be instantiated twice.
REQ-024 The storage SHALL be a single DEPTH x DW array with byte-granular write logic and a priority merge for REQ-013.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset deassert with DEPTH=16 -> init_busy=1 for exactly 16 cycles; a following read of every address returns 0.
- A writes 0xDEADBEEF to addr 3 with be=1111; one cycle later B reads addr 3 -> b_rvalid after RD_LAT cycles, b_rdata=0xDEADBEEF.
- A writes 0x11111111 with be=0011 and B writes 0x22222222 with be=1111, both to addr 5 in the same cycle -> mem[5]=0x22221111, collision pulses once.
- A writes 0xAAAA5555 to addr 7 (old 0x0) while B reads addr 7 in the same cycle -> WRITE_FIRST returns 0xAAAA5555; READ_FIRST returns 0x0; collision pulses once.
- B reads addr 20 with DEPTH=16 -> rdata=0, rvalid on time, oor_err pulses once; memory unchanged.
- Reset asserted during a 2-read burst at RD_LAT=2 -> no rvalid after reset; INIT restarts from address 0.
